// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Byte-oriented SPI slave. It runs entirely in the system clock domain: sclk,
// cs and mosi are oversampled through flip-flop synchronisers, and SPI clock
// edges are found by comparing the synchronised sclk with a delayed copy.
// The SPI mode (cpol/cpha) is selected at run time. A one-entry transmit
// holding register (tx_data/tx_load/tx_ready) feeds the transmit shifter.
// Received words are presented on rx_data with a one-cycle rx_valid strobe.
//
// Ports:
//   clk          system clock (the only clock)
//   reset        synchronous, active-high reset
//   cpol, cpha   SPI mode; must be stable while cs is low
//   cs           chip select, active low
//   sclk, mosi   SPI clock and data from the master
//   miso         SPI data to the master (0 while idle)
//   tx_data      next word to transmit
//   tx_load      captures tx_data when tx_ready is high
//   tx_ready     holding register is empty
//   rx_data      last complete received word
//   rx_valid     one-cycle strobe when rx_data updates
//   busy         a frame is in progress
//   frame_error  one-cycle strobe when cs rises on a partial word
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Bit 0 is the first stage, bit SYNC_STAGES-1 the
  // synchronised output. cs resets high so no frame start is seen out of reset.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_toggle;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_toggle = sclk_s ^ sclk_dly_q;
  // Leading edge moves sclk away from its idle level, trailing edge returns it.
  assign lead_edge   = sclk_toggle && (sclk_s != cpol);
  assign trail_edge  = sclk_toggle && (sclk_s == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign cs_fall     = !cs_s && cs_dly_q;
  assign cs_rise     = cs_s && !cs_dly_q;

  // ---------------------------------------------------------------------------
  // Core state
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [CNT_W-1:0] bit_cnt_q,     bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q,    rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q,    tx_shift_d;
  logic             miso_q,        miso_d;
  // Set when the next shift edge must present the MSB of tx_shift without
  // shifting: at the start of every word except the first word of a cpha=0
  // frame, whose MSB is already on miso when cs falls.
  logic             pending_q,     pending_d;
  logic [WIDTH-1:0] hold_q,        hold_d;
  logic             hold_full_q,   hold_full_d;
  logic [WIDTH-1:0] rx_data_q,     rx_data_d;
  logic             rx_valid_q,    rx_valid_d;
  logic             frame_error_q, frame_error_d;

  logic             consume;
  logic [WIDTH-1:0] next_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      pending_q     <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    pending_d     = pending_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    consume       = 1'b0;
    next_word     = hold_full_q ? hold_q : IDLE_FILL;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ACTIVE;
          consume    = 1'b1;
          tx_shift_d = next_word;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          pending_d  = cpha;
          // cpha=0 masters sample on the first leading edge, so the MSB must
          // already be on the line.
          miso_d     = cpha ? 1'b0 : next_word[WIDTH-1];
        end
      end

      ACTIVE: begin
        if (cs_rise) begin
          state_d       = IDLE;
          miso_d        = 1'b0;
          frame_error_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            // Word boundary: publish, and queue up the next transmit word so
            // back-to-back words need no gap.
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            consume    = 1'b1;
            tx_shift_d = next_word;
            pending_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          if (pending_q) begin
            miso_d    = tx_shift_q[WIDTH-1];
            pending_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[WIDTH-2];
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Consumption empties the holding register; a load accepted in the same
    // cycle (only possible when it was already empty) refills it for the
    // following word.
    if (consume) begin
      hold_full_d = 1'b0;
    end
    if (tx_load && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q == ACTIVE);
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Self-checking bench for spi_slave. A behavioural SPI master drives frames in
// all modes; expected received words go into a scoreboard queue that a
// separate monitor pops on every rx_valid. Expected miso words come from a
// queue model of the holding register (consumed at frame start and at every
// completed word). Directed frames follow the test plan, then randomized
// frames follow.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int HALF = 6;  // SPI half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       cpol;
  logic       cpha;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_error;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk         (clk),
    .reset       (reset),
    .cpol        (cpol),
    .cpha        (cpha),
    .cs          (cs),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_error (frame_error)
  );

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] hold_model[$];
  int         exp_rx_total = 0;
  int         exp_fe = 0;
  int         rxv_seen = 0;
  int         fe_seen = 0;
  logic       prev_rxv = 1'b0;
  logic [7:0] last_rx_model = 8'h00;
  logic [7:0] mosi_buf[4];
  logic [7:0] miso_got[4];
  logic [7:0] exp_miso[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holding-register model: one consumption returns the held word or the fill.
  function automatic logic [7:0] consume_model();
    if (hold_model.size() != 0) return hold_model.pop_front();
    return 8'hFF;
  endfunction

  // Monitor: pops the scoreboard on every rx_valid strobe.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rxv = 1'b0;
      end else begin
        if (rx_valid) begin
          rxv_seen++;
          chk("rx_valid_one_cycle", prev_rxv, 0);
          if (exp_rx_q.size() == 0) begin
            checks++;
            $display("FAIL rx_unexpected: got rx_data %0h, expected no rx_valid", rx_data);
          end else begin
            e = exp_rx_q.pop_front();
            chk("rx_data", rx_data, e);
            $display("rx word %02h (expected %02h)", rx_data, e);
          end
        end
        if (frame_error) fe_seen++;
        prev_rxv = rx_valid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic preload(input logic [7:0] d);
    @(negedge clk);
    chk("tx_ready_before_load", tx_ready, 1);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    chk("tx_ready_after_load", tx_ready, 0);
  endtask

  // One frame of nbits bits. reset_at >= 0 aborts with a reset before that bit.
  task automatic do_frame(input bit pol, input bit pha, input int nbits,
                          input bit pre_en, input logic [7:0] pre,
                          input bit mid_en, input logic [7:0] mid, input int reset_at);
    int  nw    = (nbits + 7) / 8;
    int  nfull = nbits / 8;
    bit  aborted = 1'b0;
    logic [7:0] v;

    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clk(6);
    if (pre_en) begin
      preload(pre);
      hold_model.push_back(pre);
    end

    // Reference: transmit words and received words for this frame.
    exp_miso[0] = consume_model();
    if (mid_en) hold_model.push_back(mid);
    for (int k = 0; k < nfull; k++) begin
      v = consume_model();
      if (k + 1 < nw) exp_miso[k + 1] = v;
    end
    if (reset_at < 0) begin
      for (int k = 0; k < nfull; k++) begin
        exp_rx_q.push_back(mosi_buf[k]);
        exp_rx_total++;
      end
    end

    cs = 1'b0;
    if (!pha) mosi = mosi_buf[0][7];
    wait_clk(4);
    chk("busy_in_frame", busy, 1);
    chk("tx_ready_at_start", tx_ready, 1);
    wait_clk(4);

    fork
      begin
        for (int b = 0; b < nbits; b++) begin
          if (b == reset_at) begin
            aborted = 1'b1;
            break;
          end
          sclk = ~pol;
          if (!pha) miso_got[b / 8][7 - b % 8] = miso;
          else      mosi = mosi_buf[b / 8][7 - b % 8];
          wait_clk(HALF);
          sclk = pol;
          if (pha) miso_got[b / 8][7 - b % 8] = miso;
          else if (b + 1 < nbits) mosi = mosi_buf[(b + 1) / 8][7 - (b + 1) % 8];
          wait_clk(HALF);
        end
      end
      begin
        if (mid_en) begin
          wait_clk(3 * 2 * HALF);
          tx_data = mid;
          tx_load = 1'b1;
          wait_clk(1);
          tx_load = 1'b0;
          chk("tx_ready_after_mid_load", tx_ready, 0);
        end
      end
    join

    if (aborted) begin
      reset = 1'b1;
      wait_clk(2);
      chk("rst_miso", miso, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_error", frame_error, 0);
      cs   = 1'b1;
      sclk = pol;
      mosi = 1'b0;
      wait_clk(4);
      reset = 1'b0;
      hold_model.delete();
      last_rx_model = 8'h00;
      wait_clk(8);
      $display("frame mode %0d%0d aborted by reset after %0d bits", pol, pha, reset_at);
      return;
    end

    wait_clk(8);
    cs = 1'b1;
    wait_clk(5);
    chk("busy_after_frame", busy, 0);
    chk("miso_idle", miso, 0);
    wait_clk(8);

    for (int w = 0; w < nfull; w++) begin
      chk("miso_word", miso_got[w], exp_miso[w]);
      $display("frame mode %0d%0d word %0d: mosi %02h, master got %02h (expected %02h)",
               pol, pha, w, mosi_buf[w], miso_got[w], exp_miso[w]);
    end
    if (nfull > 0) last_rx_model = mosi_buf[nfull - 1];
    if (nbits % 8 != 0) exp_fe++;
    chk("frame_error_count", fe_seen, exp_fe);
    chk("rx_data_held", rx_data, last_rx_model);
    chk("rx_valid_count", rxv_seen, exp_rx_total);
  endtask

  initial begin
    int         nw;
    int         nb;
    bit         pre_en;
    bit         mid_en;

    reset   = 1'b1;
    cs      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    wait_clk(4);
    chk("reset_miso", miso, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_error", frame_error, 0);
    reset = 1'b0;
    wait_clk(4);

    // Single-byte exchange in modes 0, 1 and 3.
    mosi_buf[0] = 8'hA5;
    do_frame(1'b0, 1'b0, 8, 1'b1, 8'h3C, 1'b0, 8'h00, -1);
    do_frame(1'b0, 1'b1, 8, 1'b1, 8'h3C, 1'b0, 8'h00, -1);
    do_frame(1'b1, 1'b1, 8, 1'b1, 8'h3C, 1'b0, 8'h00, -1);

    // Two-word frame, only the first word preloaded.
    mosi_buf[0] = 8'h12;
    mosi_buf[1] = 8'h34;
    do_frame(1'b0, 1'b0, 16, 1'b1, 8'h3C, 1'b0, 8'h00, -1);

    // Partial word, then a clean frame.
    mosi_buf[0] = 8'hE7;
    do_frame(1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 8'h00, -1);
    mosi_buf[0] = 8'h5A;
    do_frame(1'b0, 1'b0, 8, 1'b1, 8'h96, 1'b0, 8'h00, -1);

    // Reset mid-frame, then a fresh frame.
    mosi_buf[0] = 8'h81;
    do_frame(1'b0, 1'b0, 8, 1'b1, 8'h42, 1'b0, 8'h00, 4);
    mosi_buf[0] = 8'hC3;
    do_frame(1'b0, 1'b0, 8, 1'b1, 8'h69, 1'b0, 8'h00, -1);

    // Mid-frame load feeds the second word.
    mosi_buf[0] = 8'h0F;
    mosi_buf[1] = 8'hF0;
    do_frame(1'b1, 1'b0, 16, 1'b0, 8'h00, 1'b1, 8'hB7, -1);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 4; w++) mosi_buf[w] = 8'($urandom);
      nb = nw * 8;
      if ($urandom_range(0, 4) == 0) nb = nb - $urandom_range(1, 7);
      pre_en = 1'($urandom);
      mid_en = (nb >= 8) && ($urandom_range(0, 2) == 0);
      do_frame(1'($urandom), 1'($urandom), nb, pre_en, 8'($urandom),
               mid_en, 8'($urandom), -1);
    end

    chk("final_rx_valid_count", rxv_seen, exp_rx_total);
    chk("final_scoreboard_empty", exp_rx_q.size(), 0);
    chk("final_frame_error_count", fe_seen, exp_fe);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI slave sitting directly downstream of `spi_master`: it receives `sclk`, `mosi` and one chip-select line (`cs1` or `cs2`) and returns `miso`. All SPI inputs are oversampled and synchronised into the system clock domain. Mode is selected at run time by `cpol`/`cpha`, matching the master's mode inputs. A one-entry transmit holding register and a received-byte strobe give the local logic a simple handshake.

## Interface
- `WIDTH`, 8: bits per SPI word, shifted MSB first.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth on `sclk`, `cs` and `mosi`; must be at least 2.
- `IDLE_FILL`, 8'hFF: word shifted out when the transmit holding register is empty at a word boundary.

Ports:
- `clk` in 1: system clock. Only clock in the block; SPI signals are sampled, never used as clocks.
- `reset` in 1: synchronous, active-high reset.
- `cpol` in 1: SPI clock idle level. Must be stable while `cs` is low.
- `cpha` in 1: 0 = sample on the leading edge; 1 = sample on the trailing edge. Must be stable while `cs` is low.
- `cs` in 1: chip select, active low. Driven by the master's `cs1` or `cs2`.
- `sclk` in 1: SPI clock from the master.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master. Driven 0 while the block is idle.
- `tx_data` in WIDTH: next word to transmit.
- `tx_load` in 1: captures `tx_data` when `tx_ready` = 1. Ignored when `tx_ready` = 0.
- `tx_ready` out 1: holding register is empty.
- `rx_data` out WIDTH: last complete received word. Held until the next word completes.
- `rx_valid` out 1: one-cycle strobe when `rx_data` updates.
- `busy` out 1: a frame is in progress (synchronised `cs` is low).
- `frame_error` out 1: one-cycle strobe when `cs` rises with a partial word received.

## Operation
- Synchronisers: `sclk`, `cs` and `mosi` each pass through SYNC_STAGES flip-flops. A further delay register on synchronised `sclk` and `cs` provides edge detection.
- Leading edge: synchronised `sclk` leaves `cpol`. Trailing edge: it returns to `cpol`.
- Sample edge: leading when `cpha` = 0, trailing when `cpha` = 1. Shift edge: the other one.
- State machine has two states, IDLE and ACTIVE.
- IDLE → ACTIVE on the synchronised `cs` falling edge:
  - Load the transmit shift register from the holding register, or from IDLE_FILL if the holding register is empty.
  - Set `tx_ready` to 1 and clear the bit counter.
  - When `cpha` = 0, drive `miso` with the MSB of the loaded word in the same cycle.
- ACTIVE, sample edge: shift synchronised `mosi` into the receive shift register LSB; increment the bit counter.
- ACTIVE, shift edge:
  - `cpha` = 0: shift the transmit register left; `miso` takes the new MSB.
  - `cpha` = 1: the first shift edge of each word presents the MSB without shifting.
- Word completion: when the bit counter reaches WIDTH on a sample edge:
  - Register the receive shift value into `rx_data` and pulse `rx_valid`.
  - Wrap the counter to 0.
  - Reload the transmit register from the holding register or IDLE_FILL, so multi-word frames are back-to-back.
- ACTIVE → IDLE on the synchronised `cs` rising edge:
  - If the bit counter is nonzero, pulse `frame_error` and discard the partial word; `rx_data` is unchanged.
  - `miso` goes to 0.
- Holding register:
  - `tx_load` with `tx_ready` = 1 captures `tx_data` and clears `tx_ready` on the next clock.
  - The holding register is consumed at a frame start or a word boundary, which sets `tx_ready`.
  - If `tx_load` arrives in the same cycle as a consumption while the register is empty, `IDLE_FILL` is shifted out for that word and the new data is captured for the next word.
- `sclk` edges while `cs` is high are ignored.

## Timing
- Reset values: `miso` = 0, `tx_ready` = 1, `rx_data` = 0, `rx_valid` = 0, `busy` = 0, `frame_error` = 0. State is IDLE, counter and shift registers are 0, holding register is empty.
- Reset asserted mid-frame forces all of the above at the next `clk` edge, regardless of `cs`.
- Input latency: SYNC_STAGES + 1 `clk` edges (3 by default) from a raw SPI edge to the registered action. This applies to `miso` updates, `rx_valid` and `frame_error`.
- `rx_valid` is high for exactly one cycle, 3 `clk` edges after the raw sampling edge of the final bit.
- Requirements on the master:
  - SPI half-period of at least SYNC_STAGES + 2 `clk` cycles.
  - First leading edge no earlier than 4 `clk` cycles after `cs` falls.
  - `cs` rises no earlier than 4 `clk` cycles after the last trailing edge.
  - All are satisfied at `speed` = 1 MHz with a 100 MHz `clk`.

## Test plan
- Mode 0 (`cpol`=0, `cpha`=0): preload `tx_data`=8'h3C; master sends 8'hA5 → `rx_data`=8'hA5 with one `rx_valid` pulse; master receives 8'h3C; `tx_ready` returns to 1 at frame start.
- Mode 1 (`cpha`=1): same byte exchange → identical `rx_data`/`miso` results.
- Mode 3 (`cpol`=1, `cpha`=1): same byte exchange → identical `rx_data`/`miso` results; no spurious edge detected at `cs` assertion.
- Two-word frame with only 8'h3C preloaded; master sends 8'h12, 8'h34 → two `rx_valid` pulses (8'h12, then 8'h34); master receives 8'h3C, then 8'hFF.
- `cs` raised after 3 bits → `frame_error` pulses once, no `rx_valid`, `rx_data` keeps its prior value; the next full frame with 8'h5A receives correctly.
- `reset` asserted after 4 bits, then released; a fresh 8'hC3 frame → all outputs at reset values during reset; 8'hC3 received cleanly afterwards.
